lane_queue_counter: RTL and testbench
=====================================

# lane_queue_counter

Per-lane vehicle queue counter feeding the day-time lane arbiter. It converts raw arrival-sensor levels into eight 8-bit queue counts, one per lane (N1, N2, E1, E2, S1, S2, W1, W2). A lane's count drops at a fixed discharge rate while that lane's green light is on. The `lane` output bundle connects directly to the arbiter's lane input. The arbiter's 8-bit light output is fed back into `green`.

## Interface
- `NUM_LANES`, 8, number of lanes; index order N1,N2,E1,E2,S1,S2,W1,W2
- `CNT_W`, 8, queue count width
- `DEPART_DIV`, 4, clock cycles of continuous green per departing vehicle (≥1)
- `DEBOUNCE_CYC`, 3, consecutive synchronized high samples that qualify an arrival (used only with debounce compiled in; ≥1)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `sensor_in`  in  `NUM_LANES`  raw arrival sensor level per lane, asynchronous; each rising edge is one car
- `green`  in  `NUM_LANES`  per-lane green enable, synchronous to `clk`
- `clr_ovf`  in  1  one-cycle pulse; clears all sticky overflow flags
- `lane`  out  `[NUM_LANES-1:0][CNT_W-1:0]`  registered queue count per lane
- `ovf`  out  `NUM_LANES`  sticky flag: an arrival was dropped at saturation

## Operation
- Reset (`rst_n`=0 at a rising edge):
  - all `lane` counts = 0, all `ovf` = 0
  - synchronizer, edge and debounce registers = 0
  - all discharge dividers = 0
  - reset mid-operation discards pending arrivals and partial discharge progress
- Arrival path, per lane:
  - 2-FF synchronizer on `sensor_in`
  - rising-edge detect on the synchronized level gives a one-cycle `arr` pulse
  - a level held high gives exactly one arrival
- Discharge path, per lane:
  - divider counts 0..`DEPART_DIV`-1 on every cycle `green`=1
  - divider is forced to 0 on any cycle `green`=0, so partial progress is lost
  - when the divider equals `DEPART_DIV`-1 it wraps to 0 and issues `dep`, but only if count > 0
  - at count 0 the divider still wraps and no `dep` is issued
- Count update, per lane, priority as listed:
  - `arr`&`dep`: count unchanged
  - `arr` only: count+1; if count = 2^`CNT_W`-1, count holds and `ovf` sets
  - `dep` only: count−1 (never below 0)
  - neither: hold
- `ovf`:
  - set has priority over `clr_ovf` in the same cycle
  - otherwise `clr_ovf` clears all flags
- Lanes are fully independent. Any number of lanes may be green at once.

## Timing
- Arrival latency: `sensor_in` rising before edge k makes `lane` reflect +1 after edge k+3 (two sync stages, edge register, count register).
- Departure: `green` high from edge j on gives first decrement after edge j+`DEPART_DIV`-1, then one decrement every `DEPART_DIV` cycles.
- `DEPART_DIV`=1: one decrement per green cycle.
- `lane` and `ovf` are registered outputs. Neither has a combinational path from any input.
- Minimum sensor low time between cars: 2 cycles without debounce; `DEBOUNCE_CYC`+1 with debounce.

## Configuration
- `LANE_SENSOR_DEBOUNCE_EN` defined:
  - a per-lane saturating counter follows the synchronizer
  - the filtered level rises only after `DEBOUNCE_CYC` consecutive high samples
  - it falls on the first low sample
  - arrival latency grows by `DEBOUNCE_CYC` cycles
  - glitches shorter than `DEBOUNCE_CYC` cycles produce no arrival
- Not defined:
  - no filter; `DEBOUNCE_CYC` is ignored
  - every synchronized rising edge counts

## Structure
- Shared package `lane_pkg`:
  - `NUM_LANES`, `CNT_W`
  - lane index constants `LANE_N1`..`LANE_W2`
  - typedef `lane_cnt_t` (`CNT_W` bits)
  - typedef `lane_bus_t` (`[NUM_LANES-1:0]` of `lane_cnt_t`)
- Sub-module `lane_counter_cell`:
  - one lane's synchronizer, optional debounce, edge detect, divider, counter and `ovf`
  - instantiated `NUM_LANES` times in a generate loop
- Top level holds only the generate loop and the shared `clr_ovf` fan-out.

## Test plan
- Reset: hold `rst_n`=0 three cycles with sensors toggling → all `lane`=0, `ovf`=0; first count change no earlier than edge 3 after release.
- Arrivals: pulse `sensor_in[2]` (E1) five times, 4 cycles high / 4 low, `green`=0 → `lane[2]`=5, other lanes 0, `ovf`=0.
- Discharge: preload `lane[0]`=3, hold `green[0]`=1 for 20 cycles with `DEPART_DIV`=4 → decrements after cycles 4, 8, 12; then stays 0 with no underflow.
- Simultaneous event: with `lane[5]`=7 and green on, align an arrival pulse with a departure cycle → `lane[5]` stays 7 on that edge.
- Saturation: 256 arrivals on `lane[7]` → count 255 and `ovf[7]`=1; `clr_ovf` pulse → `ovf[7]`=0 while count stays 255; pulse `clr_ovf` on the same edge as a further saturating arrival → `ovf[7]` stays 1.
- Debounce (`LANE_SENSOR_DEBOUNCE_EN`, `DEBOUNCE_CYC`=3): 2-cycle glitch → no count; 3-cycle pulse → +1 after edge 6.

Source files
------------

// File: rtl/lane_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lane_pkg : shared lane count types and lane index constants. Rev 1.0
// ----------------------------------------------------------------------------
package lane_pkg;

  localparam int NUM_LANES = 8;
  localparam int CNT_W     = 8;

  localparam int LANE_N1 = 0;
  localparam int LANE_N2 = 1;
  localparam int LANE_E1 = 2;
  localparam int LANE_E2 = 3;
  localparam int LANE_S1 = 4;
  localparam int LANE_S2 = 5;
  localparam int LANE_W1 = 6;
  localparam int LANE_W2 = 7;

  typedef logic [CNT_W-1:0]          lane_cnt_t;
  typedef lane_cnt_t [NUM_LANES-1:0] lane_bus_t;

  localparam lane_cnt_t CNT_MAX = '1;

endpackage
`default_nettype wire

// File: rtl/lane_queue_counter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lane_queue_counter_if : sensor/green inputs and lane count outputs. Rev 1.0
// ----------------------------------------------------------------------------
interface lane_queue_counter_if;
  import lane_pkg::*;

  logic [NUM_LANES-1:0] sensor_in;
  logic [NUM_LANES-1:0] green;
  logic                 clr_ovf;
  lane_bus_t            lane;
  logic [NUM_LANES-1:0] ovf;

  modport master (
    output sensor_in,
    output green,
    output clr_ovf,
    input  lane,
    input  ovf
  );

  modport slave (
    input  sensor_in,
    input  green,
    input  clr_ovf,
    output lane,
    output ovf
  );

endinterface
`default_nettype wire

// File: rtl/lane_counter_cell.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lane_counter_cell : one lane's sync, optional debounce (LANE_SENSOR_DEBOUNCE_EN),
// edge detect, discharge divider, queue count and sticky overflow. Rev 1.0
// ----------------------------------------------------------------------------
module lane_counter_cell
  import lane_pkg::*;
#(
  parameter int DEPART_DIV   = 4,
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sensor_in,
  input  logic      green,
  input  logic      clr_ovf,
  output lane_cnt_t cnt,
  output logic      ovf
);

  if (DEPART_DIV < 1) begin : g_bad_depart_div
    $error("lane_counter_cell: DEPART_DIV must be >= 1");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce_cyc
    $error("lane_counter_cell: DEBOUNCE_CYC must be >= 1");
  end

  localparam int               DIV_W    = (DEPART_DIV > 1) ? $clog2(DEPART_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEPART_DIV - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             lvl;
  logic             lvl_prev_q, lvl_prev_d;
  logic             arr_q, arr_d;
  logic             dep;
  logic [DIV_W-1:0] div_q, div_d;
  lane_cnt_t        cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;

`ifdef LANE_SENSOR_DEBOUNCE_EN
  localparam int              DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            filt_q, filt_d;

  // Filtered level rises on the DEBOUNCE_CYC-th consecutive high sample, drops on any low.
  always_comb begin
    db_cnt_d = '0;
    filt_d   = 1'b0;
    if (sync2_q) begin
      db_cnt_d = (db_cnt_q == DB_LAST) ? DB_LAST : db_cnt_q + 1'b1;
      filt_d   = (db_cnt_q == DB_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      filt_q   <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_comb begin
    sync1_d    = sensor_in;
    sync2_d    = sync1_q;
    lvl_prev_d = lvl;
    arr_d      = lvl & ~lvl_prev_q;

    // Divider progress only survives uninterrupted green.
    if (!green || (div_q == DIV_LAST)) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
    dep = green && (div_q == DIV_LAST) && (cnt_q != '0);

    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (arr_q && !dep) begin
      if (cnt_q == CNT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dep && !arr_q) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
      arr_q      <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_prev_q <= lvl_prev_d;
      arr_q      <= arr_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: rtl/lane_queue_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lane_queue_counter : eight independent lane queue counters for the arbiter;
// optional sensor debounce via LANE_SENSOR_DEBOUNCE_EN. Rev 1.0
// ----------------------------------------------------------------------------
module lane_queue_counter
  import lane_pkg::*;
#(
  parameter int DEPART_DIV   = 4,
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lane_queue_counter_if.slave  lq
);

  lane_bus_t            lane_w;
  logic [NUM_LANES-1:0] ovf_w;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_counter_cell #(
      .DEPART_DIV   (DEPART_DIV),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .sensor_in (lq.sensor_in[i]),
      .green     (lq.green[i]),
      .clr_ovf   (lq.clr_ovf),
      .cnt       (lane_w[i]),
      .ovf       (ovf_w[i])
    );
  end

  assign lq.lane = lane_w;
  assign lq.ovf  = ovf_w;

endmodule
`default_nettype wire

// File: tb/tb_lane_queue_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lane_queue_counter : directed self-checking bench for lane_queue_counter.
// ----------------------------------------------------------------------------
module tb_lane_queue_counter;
  import lane_pkg::*;

`ifdef LANE_SENSOR_DEBOUNCE_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lane_queue_counter_if lq();

  lane_queue_counter #(
    .DEPART_DIV   (4),
    .DEBOUNCE_CYC (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lq    (lq)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;
  lane_bus_t exp_bus;
  int glitch_cnt;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int l, input int n);
    for (int p = 0; p < n; p++) begin
      lq.sensor_in[l] = 1'b1;
      step(4);
      lq.sensor_in[l] = 1'b0;
      step(4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    lq.sensor_in = '0;
    lq.green     = '0;
    lq.clr_ovf   = 1'b0;

    // Reset held with toggling sensors
    for (int i = 0; i < 3; i++) begin
      lq.sensor_in = ~lq.sensor_in;
      step(1);
      check("rst_lane", lq.lane, '0);
      check("rst_ovf", lq.ovf, '0);
    end

    // First arrival after release: +1 after edge k+3 (+EXTRA with debounce)
    rst_n        = 1'b1;
    lq.sensor_in = 8'h02;
    step(3 + EXTRA);
    check("release_hold", lq.lane, '0);
    step(1);
    exp_bus          = '0;
    exp_bus[LANE_N2] = 8'd1;
    check("release_arr", lq.lane, exp_bus);
    lq.sensor_in = '0;
    step(4);
    check("level_one_arr", lq.lane[LANE_N2], 1);

    // Five arrivals on E1, green off
    pulse(LANE_E1, 5);
    step(4 + EXTRA);
    exp_bus[LANE_E1] = 8'd5;
    check("arr_e1_bus", lq.lane, exp_bus);
    check("arr_e1_ovf", lq.ovf, '0);

    // Discharge N1 from 3 with DEPART_DIV=4
    pulse(LANE_N1, 3);
    step(4 + EXTRA);
    check("preload_n1", lq.lane[LANE_N1], 3);
    lq.green[LANE_N1] = 1'b1;
    step(3);
    check("dis_before_1", lq.lane[LANE_N1], 3);
    step(1);
    check("dis_1", lq.lane[LANE_N1], 2);
    step(3);
    check("dis_before_2", lq.lane[LANE_N1], 2);
    step(1);
    check("dis_2", lq.lane[LANE_N1], 1);
    step(4);
    check("dis_3", lq.lane[LANE_N1], 0);
    step(8);
    check("dis_floor", lq.lane[LANE_N1], 0);
    lq.green[LANE_N1] = 1'b0;
    exp_bus[LANE_N1] = 8'd0;
    check("dis_bus", lq.lane, exp_bus);

    // Arrival aligned with a departure on S2
    pulse(LANE_S2, 7);
    step(4 + EXTRA);
    check("preload_s2", lq.lane[LANE_S2], 7);
    lq.sensor_in[LANE_S2] = 1'b1;
    step(EXTRA);
    lq.green[LANE_S2] = 1'b1;
    step(3);
    check("sim_pre", lq.lane[LANE_S2], 7);
    step(1);
    check("sim_arr_dep", lq.lane[LANE_S2], 7);
    lq.sensor_in[LANE_S2] = 1'b0;
    step(3);
    check("sim_between", lq.lane[LANE_S2], 7);
    step(1);
    check("sim_dep", lq.lane[LANE_S2], 6);

    // A green gap discards partial divider progress
    lq.green[LANE_S2] = 1'b0;
    step(1);
    lq.green[LANE_S2] = 1'b1;
    step(3);
    lq.green[LANE_S2] = 1'b0;
    step(1);
    lq.green[LANE_S2] = 1'b1;
    step(3);
    check("div_reset", lq.lane[LANE_S2], 6);
    step(1);
    check("div_restart", lq.lane[LANE_S2], 5);
    lq.green[LANE_S2] = 1'b0;
    exp_bus[LANE_S2] = 8'd5;

    // Saturation on W2
    pulse(LANE_W2, 255);
    step(EXTRA);
    check("sat_255", lq.lane[LANE_W2], 255);
    check("sat_255_ovf", lq.ovf, '0);
    pulse(LANE_W2, 1);
    step(EXTRA);
    check("sat_hold", lq.lane[LANE_W2], 255);
    check("sat_ovf", lq.ovf, 8'h80);
    lq.clr_ovf = 1'b1;
    step(1);
    lq.clr_ovf = 1'b0;
    check("clr_ovf", lq.ovf, '0);
    check("clr_keep_cnt", lq.lane[LANE_W2], 255);
    lq.sensor_in[LANE_W2] = 1'b1;
    step(3 + EXTRA);
    lq.clr_ovf = 1'b1;
    step(1);
    lq.clr_ovf = 1'b0;
    check("ovf_set_wins", lq.ovf, 8'h80);
    lq.sensor_in[LANE_W2] = 1'b0;
    step(6);
    exp_bus[LANE_W2] = 8'd255;

    // Short glitch on E2: filtered with debounce, counted without
`ifdef LANE_SENSOR_DEBOUNCE_EN
    glitch_cnt = 0;
`else
    glitch_cnt = 1;
`endif
    lq.sensor_in[LANE_E2] = 1'b1;
    step(2);
    lq.sensor_in[LANE_E2] = 1'b0;
    step(8);
    check("glitch", lq.lane[LANE_E2], glitch_cnt);
    lq.sensor_in[LANE_E2] = 1'b1;
    step(3);
    lq.sensor_in[LANE_E2] = 1'b0;
    step(EXTRA);
    check("pulse3_pre", lq.lane[LANE_E2], glitch_cnt);
    step(1);
    check("pulse3_arr", lq.lane[LANE_E2], glitch_cnt + 1);
    step(6);
    exp_bus[LANE_E2] = 8'(glitch_cnt + 1);
    check("final_bus", lq.lane, exp_bus);
    check("final_ovf", lq.ovf, 8'h80);

    // Mid-operation reset
    lq.green = 8'hFF;
    lq.sensor_in = 8'h10;
    step(2);
    rst_n = 1'b0;
    step(1);
    check("midrst_lane", lq.lane, '0);
    check("midrst_ovf", lq.ovf, '0);
    rst_n = 1'b1;
    lq.green = '0;
    lq.sensor_in = '0;
    step(8);
    check("midrst_no_pending", lq.lane, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
